// File: rtl/sram_arbiter_pkg.sv
// Purpose : shared encodings for the inst/data SRAM arbiter.
// Latency : n/a (constants and types only).
// Backpr. : n/a.
package sram_arbiter_pkg;

    // Width of the stall request toward the pipeline controller.
    localparam int STALLREQ_W = 1;

    // Records which port owns the read data returning next cycle.
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_INST = 2'd1;
    localparam logic [1:0] GNT_DATA = 2'd2;

    // S_PASS: no deferred fetch. S_INST: one fetch waits for replay.
    typedef enum logic {
        S_PASS = 1'b0,
        S_INST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sram_arbiter_rdata_steer.sv
// Purpose : steers 1-cycle SRAM read data to the fetch or data port and holds it.
// Latency : data arrives on the owning port the cycle after issue; other port holds.
// Backpr. : none; hold registers keep outputs stable while the pipeline stalls.
// Ports   : issue_gnt (port issued this cycle), ram_rdata (memory data),
//           inst_rdata / data_rdata (per-port read data).
module sram_rdata_steer
    import sram_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        issue_gnt,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic [DATA_W-1:0] data_rdata
);

    logic [1:0]        gnt_q,       gnt_d;
    logic [DATA_W-1:0] inst_hold_q, inst_hold_d;
    logic [DATA_W-1:0] data_hold_q, data_hold_d;

    always_comb begin
        gnt_d       = issue_gnt;
        inst_hold_d = inst_hold_q;
        data_hold_d = data_hold_q;
        if (gnt_q == GNT_INST) begin
            inst_hold_d = ram_rdata;
        end
        // Stores also land here; the captured value is meaningless but harmless.
        if (gnt_q == GNT_DATA) begin
            data_hold_d = ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q       <= GNT_NONE;
            inst_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            gnt_q       <= gnt_d;
            inst_hold_q <= inst_hold_d;
            data_hold_q <= data_hold_d;
        end
    end

    assign inst_rdata = (gnt_q == GNT_INST) ? ram_rdata : inst_hold_q;
    assign data_rdata = (gnt_q == GNT_DATA) ? ram_rdata : data_hold_q;

endmodule

// File: rtl/sram_arbiter.sv
// Purpose : shares one single-port SRAM between fetch and data; data wins, fetch replays.
// Latency : issue is combinational (0 cycles); read data 1 cycle after issue.
// Backpr. : a deferred fetch raises stallreq while pending; IF inputs ignored then.
// Ports   : inst_sram_* (fetch bus), data_sram_* (load/store bus), ram_* (unified SRAM),
//           stallreq (freeze IF/ID), conflict_cnt (preemption counter).
// Config  : define SRAM_ARB_PERF_CNT_EN to build the conflict counter; otherwise it reads 0.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // multiple of 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_sram_en,
    input  logic [ADDR_W-1:0]     inst_sram_addr,
    output logic [DATA_W-1:0]     inst_sram_rdata,
    input  logic                  data_sram_en,
    input  logic [DATA_W/8-1:0]   data_sram_wen,
    input  logic [ADDR_W-1:0]     data_sram_addr,
    input  logic [DATA_W-1:0]     data_sram_wdata,
    output logic [DATA_W-1:0]     data_sram_rdata,
    output logic                  ram_en,
    output logic [DATA_W/8-1:0]   ram_wen,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic [STALLREQ_W-1:0] stallreq,
    output logic [31:0]           conflict_cnt
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [1:0]        issue_gnt;
    logic              preempt;     // data took the SRAM while a fetch wanted it

    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        issue_gnt   = GNT_NONE;
        preempt     = 1'b0;
        ram_en      = 1'b0;
        ram_wen     = '0;
        ram_addr    = '0;
        ram_wdata   = '0;

        // Data always owns the SRAM when it asks, in either state.
        if (data_sram_en) begin
            ram_en    = 1'b1;
            ram_wen   = data_sram_wen;
            ram_addr  = data_sram_addr;
            ram_wdata = data_sram_wdata;
            issue_gnt = GNT_DATA;
        end

        case (state_q)
            S_PASS: begin
                if (data_sram_en) begin
                    if (inst_sram_en) begin
                        preempt     = 1'b1;
                        pend_addr_d = inst_sram_addr;
                        state_d     = S_INST;
                    end
                end else if (inst_sram_en) begin
                    ram_en    = 1'b1;
                    ram_addr  = inst_sram_addr;
                    issue_gnt = GNT_INST;
                end
            end
            S_INST: begin
                // IF is frozen here, so the live fetch inputs are stale and ignored.
                if (data_sram_en) begin
                    preempt = 1'b1;
                end else begin
                    ram_en    = 1'b1;
                    ram_addr  = pend_addr_q;
                    issue_gnt = GNT_INST;
                    state_d   = S_PASS;
                end
            end
            default: state_d = S_PASS;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_PASS;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign stallreq = STALLREQ_W'(state_q == S_INST);

`ifdef SRAM_ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q + {31'd0, preempt};   // wraps naturally
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`else
    logic unused_preempt;
    assign unused_preempt = preempt;
    assign conflict_cnt   = '0;
`endif

    sram_rdata_steer #(
        .DATA_W (DATA_W)
    ) u_rdata_steer (
        .clk        (clk),
        .rst        (rst),
        .issue_gnt  (issue_gnt),
        .ram_rdata  (ram_rdata),
        .inst_rdata (inst_sram_rdata),
        .data_rdata (data_sram_rdata)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [0:0]  stallreq;
    logic [31:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of deferred fetch addresses, who owns next
    // cycle's read data, and the last value each port has seen.
    logic [31:0] m_pend[$];
    int          m_owner;          // 0 none, 1 fetch, 2 data load, 3 data store
    logic [31:0] m_inst_val;
    logic [31:0] m_data_val;
    bit          m_data_known;
    logic [31:0] m_cnt;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .ram_en          (ram_en),
        .ram_wen         (ram_wen),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata),
        .stallreq        (stallreq),
        .conflict_cnt    (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_owner      = 0;
        m_inst_val   = 32'd0;
        m_data_val   = 32'd0;
        m_data_known = 1'b1;
        m_cnt        = 32'd0;
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef SRAM_ARB_PERF_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    // One clock cycle: drive after the falling edge, check 1 time unit later,
    // then advance the model to what the next rising edge should produce.
    task automatic step(input logic ie, input logic [31:0] ia,
                        input logic de, input logic [3:0] dw,
                        input logic [31:0] da, input logic [31:0] dd,
                        input logic [31:0] rd);
        logic        e_en;
        logic [3:0]  e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        int          nxt_owner;
        bit          stall_exp;
        @(negedge clk);
        inst_sram_en    = ie;
        inst_sram_addr  = ia;
        data_sram_en    = de;
        data_sram_wen   = dw;
        data_sram_addr  = da;
        data_sram_wdata = dd;
        ram_rdata       = rd;
        #1;
        // Read data returned for whatever was issued last cycle.
        if (m_owner == 1) m_inst_val = rd;
        if (m_owner == 2) begin
            m_data_val   = rd;
            m_data_known = 1'b1;
        end
        if (m_owner == 3) m_data_known = 1'b0;

        stall_exp = (m_pend.size() != 0);
        e_en = 1'b0; e_wen = 4'd0; e_addr = 32'd0; e_wdata = 32'd0; nxt_owner = 0;
        if (de) begin
            e_en = 1'b1; e_wen = dw; e_addr = da; e_wdata = dd;
            nxt_owner = (dw == 4'd0) ? 2 : 3;
        end else if (stall_exp) begin
            e_en = 1'b1; e_addr = m_pend[0]; nxt_owner = 1;
        end else if (ie) begin
            e_en = 1'b1; e_addr = ia; nxt_owner = 1;
        end

        chk("stallreq", {31'd0, stallreq}, {31'd0, stall_exp});
        chk("ram_en", {31'd0, ram_en}, {31'd0, e_en});
        if (e_en) begin
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_wen", {28'd0, ram_wen}, {28'd0, e_wen});
            if (e_wen != 4'd0) chk("ram_wdata", ram_wdata, e_wdata);
        end
        chk("inst_rdata", inst_sram_rdata, m_inst_val);
        if (m_data_known) chk("data_rdata", data_sram_rdata, m_data_val);
        chk("conflict_cnt", conflict_cnt, exp_cnt());

        // Advance the model across the coming rising edge.
        if (de) begin
            if (stall_exp || ie) m_cnt = m_cnt + 32'd1;
            if (!stall_exp && ie) m_pend.push_back(ia);
        end else if (stall_exp) begin
            void'(m_pend.pop_front());
        end
        m_owner = nxt_owner;
    endtask

    task automatic idle(input logic [31:0] rd);
        step(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, rd);
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] fa;
        model_reset();
        // Reset asserted with both requesters active.
        rst             = 1'b0;
        inst_sram_en    = 1'b1;
        inst_sram_addr  = 32'h1000_0000;
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'd0;
        data_sram_addr  = 32'h2000_0000;
        data_sram_wdata = 32'd0;
        ram_rdata       = 32'h1234_5678;
        #1;
        chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
        chk("rst_inst_rdata", inst_sram_rdata, 32'd0);
        chk("rst_data_rdata", data_sram_rdata, 32'd0);
        chk("rst_cnt", conflict_cnt, 32'd0);
        inst_sram_en = 1'b0;
        data_sram_en = 1'b0;
        #1;
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        #1;
        rst = 1'b1;

        // Fetch only; first fetch after release issues in its own cycle.
        step(1'b1, 32'hBFC0_0000, 1'b0, 4'd0, 32'd0, 32'd0, $urandom);
        chk("fetch_addr", ram_addr, 32'hBFC0_0000);
        idle(32'h2401_0001);
        chk("fetch_rdata", inst_sram_rdata, 32'h2401_0001);
        chk("fetch_stall", {31'd0, stallreq}, 32'd0);

        // Single conflict.
        step(1'b1, 32'hBFC0_0004, 1'b1, 4'd0, 32'h8000_1000, 32'd0, $urandom);
        chk("conf_t_addr", ram_addr, 32'h8000_1000);
        r1 = $urandom;
        step(1'b1, 32'hBFC0_0008, 1'b0, 4'd0, 32'd0, 32'd0, r1);
        chk("conf_t1_addr", ram_addr, 32'hBFC0_0004);
        chk("conf_t1_stall", {31'd0, stallreq}, 32'd1);
        chk("conf_t1_drdata", data_sram_rdata, r1);
        r2 = $urandom;
        idle(r2);
        chk("conf_t2_irdata", inst_sram_rdata, r2);
        chk("conf_t2_stall", {31'd0, stallreq}, 32'd0);

        // Back-to-back data requests extend the stall; pending address held.
        fa = 32'hBFC0_0100;
        step(1'b1, fa, 1'b1, 4'd0, 32'h8000_2000, 32'd0, $urandom);
        step(1'b1, 32'hBFC0_0FFC, 1'b1, 4'd0, 32'h8000_2004, 32'd0, $urandom);
        chk("b2b_t1_stall", {31'd0, stallreq}, 32'd1);
        idle($urandom);
        chk("b2b_t2_stall", {31'd0, stallreq}, 32'd1);
        chk("b2b_replay_addr", ram_addr, fa);
        idle($urandom);

        // Store conflict: replayed fetch must not write.
        step(1'b1, 32'hBFC0_0200, 1'b1, 4'hF, 32'h8000_3000, 32'hDEAD_BEEF, $urandom);
        chk("st_wen", {28'd0, ram_wen}, 32'hF);
        chk("st_wdata", ram_wdata, 32'hDEAD_BEEF);
        idle($urandom);
        chk("st_replay_wen", {28'd0, ram_wen}, 32'd0);
        chk("st_replay_addr", ram_addr, 32'hBFC0_0200);
        idle($urandom);

        // Reset while a fetch is pending drops it.
        step(1'b1, 32'hBFC0_0300, 1'b1, 4'd0, 32'h8000_4000, 32'd0, $urandom);
        @(negedge clk);
        inst_sram_en = 1'b0;
        data_sram_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_mid_stall", {31'd0, stallreq}, 32'd0);
        chk("rst_mid_ram_en", {31'd0, ram_en}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle($urandom);
        idle($urandom);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic ie;
            logic de;
            logic [3:0] dw;
            ie = 1'($urandom_range(0, 1));
            de = ($urandom_range(0, 9) < 4);
            dw = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            step(ie, $urandom, de, dw, $urandom, $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
